// File: rtl/pe1x1_ctrl.sv
// Sequencer and lane accumulator for a 1x1 PE array: issues fmap/weight reads per channel and emits one row per output channel.
// Optional build macro PE1X1_CTRL_SAT_EN selects saturating lane adds instead of wrap-around.
module pe1x1_ctrl #(
  parameter int unsigned INPUT_NUM = 7,
  parameter int unsigned IW        = 24,
  parameter int unsigned FW        = 8,
  parameter int unsigned CNT_W     = 10,
  parameter int unsigned WA_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [CNT_W-1:0]               cfg_cin,
  input  logic [CNT_W-1:0]               cfg_cout,
  output logic                           busy,
  output logic                           done,
  output logic                           fmap_rd_en,
  output logic [CNT_W-1:0]               fmap_addr,
  output logic                           wht_rd_en,
  output logic [WA_W-1:0]                wht_addr,
  input  logic [INPUT_NUM*(IW+FW)-1:0]   pe_res_i,
  output logic [INPUT_NUM*(IW+FW)-1:0]   acc_o,
  output logic                           acc_valid,
  output logic [CNT_W-1:0]               acc_co,
  input  logic                           acc_ready
);

  localparam int unsigned D  = IW + FW;
  localparam int unsigned PW = INPUT_NUM * D;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_OUT   = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [CNT_W-1:0] cin_q;
  logic [CNT_W-1:0] cin_d;
  logic [CNT_W-1:0] cout_q;
  logic [CNT_W-1:0] cout_d;
  logic             busy_d;
  logic             done_d;
  logic             rd_en_d;
  logic [CNT_W-1:0] fmap_addr_d;
  logic [WA_W-1:0]  wht_addr_d;
  logic             acc_valid_d;
  logic [CNT_W-1:0] acc_co_d;

  // Tag pipe: stage 1 covers buffer read latency, stage 2 the PE output register
  logic t1_valid;
  logic t1_first;
  logic t1_last;
  logic t2_valid;
  logic t2_first;
  logic t2_last;

  logic [PW-1:0] acc_d;

  // Two's-complement lane add; saturating variant clamps on signed overflow
  function automatic logic [D-1:0] lane_add(input logic [D-1:0] a, input logic [D-1:0] b);
    logic [D-1:0] s;
    s = a + b;
`ifdef PE1X1_CTRL_SAT_EN
    if ((a[D-1] == b[D-1]) && (s[D-1] != a[D-1])) begin
      s = a[D-1] ? {1'b1, {(D-1){1'b0}}} : {1'b0, {(D-1){1'b1}}};
    end
`endif
    return s;
  endfunction

  // Next-state and next-output logic; fmap_addr doubles as the input-channel counter
  always_comb begin
    state_d     = state_q;
    cin_d       = cin_q;
    cout_d      = cout_q;
    rd_en_d     = 1'b0;
    fmap_addr_d = fmap_addr;
    wht_addr_d  = wht_addr;
    acc_valid_d = 1'b0;
    acc_co_d    = acc_co;
    done_d      = 1'b0;
    busy_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((cfg_cin != '0) && (cfg_cout != '0)) begin
            cin_d       = cfg_cin;
            cout_d      = cfg_cout;
            acc_co_d    = '0;
            fmap_addr_d = '0;
            wht_addr_d  = '0;
            rd_en_d     = 1'b1;
            state_d     = S_RUN;
          end else begin
            state_d = S_FIN;
          end
        end
      end

      S_RUN: begin
        wht_addr_d = wht_addr + WA_W'(1);
        if (fmap_addr == (cin_q - CNT_W'(1))) begin
          fmap_addr_d = '0;
          state_d     = S_DRAIN;
        end else begin
          fmap_addr_d = fmap_addr + CNT_W'(1);
          rd_en_d     = 1'b1;
        end
      end

      S_DRAIN: begin
        if (t2_valid && t2_last) begin
          acc_valid_d = 1'b1;
          state_d     = S_OUT;
        end
      end

      S_OUT: begin
        if (acc_ready) begin
          if (acc_co == (cout_q - CNT_W'(1))) begin
            done_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            acc_co_d = acc_co + CNT_W'(1);
            rd_en_d  = 1'b1;
            state_d  = S_RUN;
          end
        end else begin
          acc_valid_d = 1'b1;
        end
      end

      // Zero-count launches arrive here with done low and spend one extra cycle raising it
      S_FIN: begin
        if (done) begin
          state_d = S_IDLE;
        end else begin
          done_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered control outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cin_q      <= '0;
      cout_q     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fmap_rd_en <= 1'b0;
      wht_rd_en  <= 1'b0;
      fmap_addr  <= '0;
      wht_addr   <= '0;
      acc_valid  <= 1'b0;
      acc_co     <= '0;
    end else begin
      state_q    <= state_d;
      cin_q      <= cin_d;
      cout_q     <= cout_d;
      busy       <= busy_d;
      done       <= done_d;
      fmap_rd_en <= rd_en_d;
      wht_rd_en  <= rd_en_d;
      fmap_addr  <= fmap_addr_d;
      wht_addr   <= wht_addr_d;
      acc_valid  <= acc_valid_d;
      acc_co     <= acc_co_d;
    end
  end

  // Tag pipe follows each issued read to the cycle its product is on pe_res_i
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t1_valid <= 1'b0;
      t1_first <= 1'b0;
      t1_last  <= 1'b0;
      t2_valid <= 1'b0;
      t2_first <= 1'b0;
      t2_last  <= 1'b0;
    end else begin
      t1_valid <= fmap_rd_en;
      t1_first <= fmap_rd_en && (fmap_addr == '0);
      t1_last  <= fmap_rd_en && (fmap_addr == (cin_q - CNT_W'(1)));
      t2_valid <= t1_valid;
      t2_first <= t1_first;
      t2_last  <= t1_last;
    end
  end

  for (genvar k = 0; k < INPUT_NUM; k++) begin : g_lane
    assign acc_d[k*D +: D] = t2_first ? pe_res_i[k*D +: D]
                                      : lane_add(acc_o[k*D +: D], pe_res_i[k*D +: D]);
  end

  // Lane accumulators; the first product of a row overwrites instead of adding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_o <= '0;
    end else if (t2_valid) begin
      acc_o <= acc_d;
    end
  end

endmodule
